// File: rtl/ice_msg_pkg.sv
// ----------------------------------------------------------------------------
// ice_msg_pkg
// Shared definitions for the ICE ACK/NAK message path. The ACK/NAK generator
// and the receiver both use these values, so the frame format lives in this
// one place.
//   MSG_TYPE_ACK / MSG_TYPE_NAK : type byte values (first byte of a frame)
//   MSG_LEN_NONE                : the only legal length byte (no payload)
//   ACK_FRAME_LEN               : bytes in a well-formed ACK/NAK frame
//   ack_rx_state_e              : receiver frame-parser state encoding
// ----------------------------------------------------------------------------
package ice_msg_pkg;

  localparam logic [7:0] MSG_TYPE_ACK  = 8'h00;
  localparam logic [7:0] MSG_TYPE_NAK  = 8'h01;
  localparam logic [7:0] MSG_LEN_NONE  = 8'h00;
  localparam int         ACK_FRAME_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,   // between frames
    ST_TYPE,   // frame open, waiting for the type byte
    ST_EID,    // waiting for the event-ID byte
    ST_LEN,    // waiting for the length byte
    ST_END,    // complete frame seen, waiting for frame_valid to drop
    ST_DRAIN   // ignoring the rest of a frame until frame_valid drops
  } ack_rx_state_e;

endpackage

// File: rtl/ack_timeout_timer.sv
// ----------------------------------------------------------------------------
// ack_timeout_timer
// Counts cycles while a request is outstanding and flags expiry.
//   clk, reset : clock, synchronous active-high reset
//   arm        : restart counting from zero
//   clear      : request finished (completed or timed out); counter to zero
//   run        : a request is outstanding; count while high
//   expire     : high while running with TIMEOUT_CYCLES cycles elapsed
// The counter saturates at its terminal value, so expire stays asserted
// until the owner acts on it with clear or arm. That lets the owner delay
// firing by a cycle without losing the expiry.
// ----------------------------------------------------------------------------
module ack_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic arm,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: give every combinational output a default value before any branch
  // so that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (arm || clear) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: use non-blocking assignments in clocked blocks so that every flop
  // samples values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ack_receiver.sv
// ----------------------------------------------------------------------------
// ack_receiver
// Decodes 3-byte ACK/NAK frames {type, event ID, length=0} from a framed byte
// stream and tracks one outstanding request by event ID, with a timeout.
//   clk, reset                 : clock, synchronous active-high reset
//   message_data[7:0]          : incoming frame byte
//   message_data_valid         : message_data holds a byte this cycle
//   message_frame_valid        : high for a whole frame, low between frames
//   arm, expect_eid[7:0]       : start waiting for a response to expect_eid
//   waiting                    : a request is outstanding
//   ack_received, nak_received : matching ACK / NAK completed the request
//   rx_eid[7:0]                : event ID of the last well-formed ACK/NAK
//   eid_mismatch               : well-formed frame did not match (or idle)
//   frame_error                : malformed ACK/NAK frame
//   timeout                    : request expired
// All event outputs are registered one-cycle pulses.
// ----------------------------------------------------------------------------
module ack_receiver
  import ice_msg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] message_data,
  input  logic       message_data_valid,
  input  logic       message_frame_valid,
  input  logic       arm,
  input  logic [7:0] expect_eid,
  output logic       waiting,
  output logic       ack_received,
  output logic       nak_received,
  output logic [7:0] rx_eid,
  output logic       eid_mismatch,
  output logic       frame_error,
  output logic       timeout
);

  ack_rx_state_e state_q, state_d;
  logic       is_nak_q, is_nak_d;
  logic [7:0] eid_r_q, eid_r_d;
  logic       err_flag_q, err_flag_d;
  logic [7:0] exp_eid_q, exp_eid_d;
  logic       waiting_q, waiting_d;
  logic [7:0] rx_eid_q, rx_eid_d;
  logic       ack_q, ack_d;
  logic       nak_q, nak_d;
  logic       mismatch_q, mismatch_d;
  logic       frame_err_q, frame_err_d;
  logic       timeout_q, timeout_d;
  logic       prev_fv_q;

  logic accept;
  logic report;
  logic match;
  logic expire;
  logic fire;

  assign accept = message_frame_valid && message_data_valid;

  // Frame parser.
  always_comb begin
    state_d     = state_q;
    is_nak_d    = is_nak_q;
    eid_r_d     = eid_r_q;
    err_flag_d  = err_flag_q;
    frame_err_d = 1'b0;
    report      = 1'b0;

    unique case (state_q)
      // IDLE and TYPE share the type-byte decode: a frame may deliver its
      // type byte in the very cycle frame_valid rises.
      ST_IDLE, ST_TYPE: begin
        if (!message_frame_valid) begin
          if (state_q == ST_TYPE) frame_err_d = 1'b1;
          state_d = ST_IDLE;
        end else if ((state_q == ST_IDLE) && prev_fv_q) begin
          // frame_valid already high when we came out of reset: this is the
          // tail of a frame cut by reset, so swallow it silently.
          state_d = ST_DRAIN;
        end else if (accept) begin
          if (message_data == MSG_TYPE_ACK) begin
            is_nak_d = 1'b0;
            state_d  = ST_EID;
          end else if (message_data == MSG_TYPE_NAK) begin
            is_nak_d = 1'b1;
            state_d  = ST_EID;
          end else begin
            state_d  = ST_DRAIN;   // some other message type: not ours
          end
        end else begin
          state_d = ST_TYPE;
        end
      end

      ST_EID: begin
        if (!message_frame_valid) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (accept) begin
          eid_r_d = message_data;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (!message_frame_valid) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (accept) begin
          if (message_data == MSG_LEN_NONE) begin
            state_d = ST_END;
          end else begin
            err_flag_d = 1'b1;
            state_d    = ST_DRAIN;
          end
        end
      end

      ST_END: begin
        if (!message_frame_valid) begin
          report  = 1'b1;
          state_d = ST_IDLE;
        end else if (accept) begin
          err_flag_d = 1'b1;
          state_d    = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!message_frame_valid) begin
          frame_err_d = err_flag_q;
          err_flag_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Request tracking. A report is judged against the request as it stood
  // before this edge; an arm in the same cycle then installs the new request.
  // A mismatch report holds off a pending expiry by one cycle (the counter
  // saturates) so that no two event pulses share a cycle.
  assign match = report && waiting_q && (eid_r_q == exp_eid_q);
  assign fire  = expire && !report && !arm;

  always_comb begin
    ack_d      = match && !is_nak_q;
    nak_d      = match && is_nak_q;
    mismatch_d = report && !match;
    rx_eid_d   = report ? eid_r_q : rx_eid_q;
    timeout_d  = fire;
    waiting_d  = waiting_q;
    exp_eid_d  = exp_eid_q;
    if (match || fire) waiting_d = 1'b0;
    if (arm) begin
      waiting_d = 1'b1;
      exp_eid_d = expect_eid;
    end
  end

  ack_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .arm    (arm),
    .clear  (match || fire),
    .run    (waiting_q),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_nak_q    <= 1'b0;
      eid_r_q     <= 8'h00;
      err_flag_q  <= 1'b0;
      exp_eid_q   <= 8'h00;
      waiting_q   <= 1'b0;
      rx_eid_q    <= 8'h00;
      ack_q       <= 1'b0;
      nak_q       <= 1'b0;
      mismatch_q  <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_nak_q    <= is_nak_d;
      eid_r_q     <= eid_r_d;
      err_flag_q  <= err_flag_d;
      exp_eid_q   <= exp_eid_d;
      waiting_q   <= waiting_d;
      rx_eid_q    <= rx_eid_d;
      ack_q       <= ack_d;
      nak_q       <= nak_d;
      mismatch_q  <= mismatch_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  // NOTE: this flop is deliberately left out of reset. It must keep sampling
  // frame_valid while reset is held, so that the first cycle after reset knows
  // whether it landed in the middle of a frame.
  always_ff @(posedge clk) begin
    prev_fv_q <= message_frame_valid;
  end

  assign waiting      = waiting_q;
  assign ack_received = ack_q;
  assign nak_received = nak_q;
  assign rx_eid       = rx_eid_q;
  assign eid_mismatch = mismatch_q;
  assign frame_error  = frame_err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_ack_receiver.sv
// ----------------------------------------------------------------------------
// tb_ack_receiver
// Self-checking bench for ack_receiver with TIMEOUT_CYCLES=16: a cycle-by-
// cycle vector table, hand-written corner-case sequences, then random frame
// traffic compared against a frame-level reference model.
// Output vector layout: {waiting, ack, nak, mismatch, frame_error, timeout,
// rx_eid[7:0]}.
// ----------------------------------------------------------------------------
module tb_ack_receiver;
  import ice_msg_pkg::*;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] message_data;
  logic       message_data_valid;
  logic       message_frame_valid;
  logic       arm;
  logic [7:0] expect_eid;
  logic       waiting, ack_received, nak_received;
  logic [7:0] rx_eid;
  logic       eid_mismatch, frame_error, timeout;

  always #5 clk = ~clk;

  ack_receiver #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
    .clk                 (clk),
    .reset               (reset),
    .message_data        (message_data),
    .message_data_valid  (message_data_valid),
    .message_frame_valid (message_frame_valid),
    .arm                 (arm),
    .expect_eid          (expect_eid),
    .waiting             (waiting),
    .ack_received        (ack_received),
    .nak_received        (nak_received),
    .rx_eid              (rx_eid),
    .eid_mismatch        (eid_mismatch),
    .frame_error         (frame_error),
    .timeout             (timeout)
  );

  typedef struct {
    logic       fv;
    logic       dv;
    logic [7:0] data;
    logic       arm;
    logic [7:0] eid;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic [13:0] exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  vec_t  tbl[$];
  stim_t sq[$];

  // Reference model state (frame level).
  logic [7:0] mq[$];
  bit         m_in_frame;
  bit         m_wait;
  logic [7:0] m_exp;
  logic [7:0] m_rx;
  int         m_edge;
  int         m_deadline;

  function automatic logic [13:0] outs();
    return {waiting, ack_received, nak_received, eid_mismatch, frame_error,
            timeout, rx_eid};
  endfunction

  function automatic logic [13:0] ev(input bit w, a, n, m, f, t,
                                     input logic [7:0] rx);
    return {w, a, n, m, f, t, rx};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic fv, dv, input logic [7:0] d,
                     input logic a, input logic [7:0] e);
    message_frame_valid = fv;
    message_data_valid  = dv;
    message_data        = d;
    arm                 = a;
    expect_eid          = e;
    @(posedge clk);
    #1;
  endtask

  task automatic bytes3(input logic [7:0] b0, b1, b2);
    cyc(1, 1, b0, 0, 8'h00);
    cyc(1, 1, b1, 0, 8'h00);
    cyc(1, 1, b2, 0, 8'h00);
  endtask

  task automatic row(input logic fv, dv, input logic [7:0] d, input logic a,
                     input logic [7:0] e, input logic [13:0] x);
    vec_t v;
    v.in.fv = fv; v.in.dv = dv; v.in.data = d; v.in.arm = a; v.in.eid = e;
    v.exp = x;
    tbl.push_back(v);
  endtask

  task automatic push(input logic fv, dv, input logic [7:0] d);
    stim_t s;
    s.fv = fv; s.dv = dv; s.data = d;
    s.arm = ($urandom_range(0, 15) == 0);
    s.eid = 8'h40 + 8'($urandom_range(0, 3));
    sq.push_back(s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 8'h00, 0, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    reset = 1'b0;
  endtask

  // Model one clock edge from the frame rules: the bytes of a frame are
  // collected and the whole frame is classified when frame_valid falls.
  task automatic model_edge(input stim_t s, output logic [13:0] exp);
    bit ack = 0, nak = 0, mm = 0, fe = 0, to = 0, good = 0, gnak = 0;
    logic [7:0] geid = 8'h00;
    m_edge++;
    if (m_in_frame && !s.fv) begin
      m_in_frame = 0;
      if (mq.size() == 0) fe = 1;
      else if (mq[0] != MSG_TYPE_ACK && mq[0] != MSG_TYPE_NAK) fe = 0;
      else if (mq.size() != ACK_FRAME_LEN || mq[2] != 8'h00) fe = 1;
      else begin
        good = 1; geid = mq[1]; gnak = (mq[0] == MSG_TYPE_NAK);
      end
    end
    if (s.fv) begin
      if (!m_in_frame) begin
        m_in_frame = 1;
        mq.delete();
      end
      if (s.dv) mq.push_back(s.data);
    end
    if (good) begin
      m_rx = geid;
      if (m_wait && geid == m_exp) begin
        if (gnak) nak = 1; else ack = 1;
        m_wait = 0;
      end else begin
        mm = 1;
      end
    end
    if (m_wait && m_edge >= m_deadline && !good && !s.arm) begin
      to = 1;
      m_wait = 0;
    end
    if (s.arm) begin
      m_wait = 1;
      m_exp = s.eid;
      m_deadline = m_edge + int'(T);
    end
    exp = {m_wait, ack, nak, mm, fe, to, m_rx};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [13:0] x;
    logic [7:0]  fr[$];

    // ---------------- reset state ----------------
    reset = 1'b1;
    cyc(1, 1, 8'hA5, 1, 8'h5A);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("reset_outputs", outs(), 14'h0000);
    reset = 1'b0;

    // ---------------- vector table ----------------
    row(0, 0, 8'h00, 1, 8'h5A, ev(1, 0, 0, 0, 0, 0, 8'h00)); // 0 arm 5A
    row(1, 1, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h00));
    row(1, 1, 8'h5A, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h00));
    row(1, 1, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h00));
    row(0, 0, 8'h00, 0, 8'h00, ev(0, 1, 0, 0, 0, 0, 8'h5A)); // 4 ack
    row(0, 0, 8'h00, 0, 8'h00, ev(0, 0, 0, 0, 0, 0, 8'h5A));
    row(0, 0, 8'h00, 1, 8'h11, ev(1, 0, 0, 0, 0, 0, 8'h5A)); // 6 arm 11
    row(1, 1, 8'h01, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h5A));
    row(1, 0, 8'hAA, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h5A));
    row(1, 1, 8'h11, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h5A));
    row(1, 0, 8'hCC, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h5A));
    row(1, 0, 8'hCC, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h5A));
    row(1, 0, 8'hCC, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h5A));
    row(1, 1, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h5A));
    row(0, 0, 8'h00, 0, 8'h00, ev(0, 0, 1, 0, 0, 0, 8'h11)); // 14 nak
    row(0, 0, 8'h00, 0, 8'h00, ev(0, 0, 0, 0, 0, 0, 8'h11));
    row(0, 0, 8'h00, 1, 8'h77, ev(1, 0, 0, 0, 0, 0, 8'h11)); // 16 arm 77
    row(1, 1, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(1, 1, 8'h5A, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(1, 1, 8'h03, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11)); // bad length
    row(0, 0, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 1, 0, 8'h11)); // 20 error
    row(1, 1, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(1, 1, 8'h5A, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(1, 1, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(1, 1, 8'hFF, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11)); // extra byte
    row(0, 0, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 1, 0, 8'h11)); // 25 error
    row(1, 1, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(1, 1, 8'h5A, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(0, 0, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 1, 0, 8'h11)); // 28 short
    row(1, 1, 8'h7E, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11)); // other type
    row(1, 1, 8'h5A, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11));
    row(0, 0, 8'h00, 0, 8'h00, ev(1, 0, 0, 0, 0, 0, 8'h11)); // 31 silent
    row(0, 0, 8'h00, 0, 8'h00, ev(0, 0, 0, 0, 0, 1, 8'h11)); // 32 = arm+16
    row(0, 0, 8'h00, 0, 8'h00, ev(0, 0, 0, 0, 0, 0, 8'h11));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].in.fv, tbl[i].in.dv, tbl[i].in.data, tbl[i].in.arm,
          tbl[i].in.eid);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // ---------------- mismatch and unsolicited ----------------
    cyc(0, 0, 8'h00, 1, 8'h22);
    bytes3(MSG_TYPE_ACK, 8'h23, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("mismatch_wrong_eid", outs(), ev(1, 0, 0, 1, 0, 0, 8'h23));
    bytes3(MSG_TYPE_ACK, 8'h22, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("ack_after_mismatch", outs(), ev(0, 1, 0, 0, 0, 0, 8'h22));
    bytes3(MSG_TYPE_ACK, 8'h22, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("unsolicited_ack", outs(), ev(0, 0, 0, 1, 0, 0, 8'h22));

    // ---------------- completion in the expiry cycle ----------------
    cyc(0, 0, 8'h00, 1, 8'h01);                 // arm edge n
    repeat (12) cyc(0, 0, 8'h00, 0, 8'h00);     // n+1 .. n+12
    bytes3(MSG_TYPE_ACK, 8'h01, 8'h00);         // n+13 .. n+15
    cyc(0, 0, 8'h00, 0, 8'h00);                 // n+16: report and expiry
    check("race_ack_wins", outs(), ev(0, 1, 0, 0, 0, 0, 8'h01));
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("race_no_late_timeout", outs(), ev(0, 0, 0, 0, 0, 0, 8'h01));

    // ---------------- arm in the report cycle ----------------
    cyc(0, 0, 8'h00, 1, 8'h22);
    bytes3(MSG_TYPE_ACK, 8'h22, 8'h00);
    cyc(0, 0, 8'h00, 1, 8'h33);
    check("arm_with_report", outs(), ev(1, 1, 0, 0, 0, 0, 8'h22));
    bytes3(MSG_TYPE_ACK, 8'h22, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("old_eid_replaced", outs(), ev(1, 0, 0, 1, 0, 0, 8'h22));
    bytes3(MSG_TYPE_NAK, 8'h33, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("new_eid_nak", outs(), ev(0, 0, 1, 0, 0, 0, 8'h33));

    // ---------------- reset mid-frame ----------------
    cyc(0, 0, 8'h00, 1, 8'h44);
    cyc(1, 1, MSG_TYPE_ACK, 0, 8'h00);
    cyc(1, 1, 8'h44, 0, 8'h00);
    reset = 1'b1;
    cyc(1, 1, 8'h00, 0, 8'h00);
    reset = 1'b0;
    check("reset_mid_frame", outs(), 14'h0000);
    bytes3(MSG_TYPE_ACK, 8'h44, 8'h00);         // tail looks like a frame
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("reset_tail_silent", outs(), 14'h0000);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("reset_tail_silent2", outs(), 14'h0000);
    bytes3(MSG_TYPE_ACK, 8'h44, 8'h00);
    cyc(0, 0, 8'h00, 0, 8'h00);
    check("after_reset_frame", outs(), ev(0, 0, 0, 1, 0, 0, 8'h44));

    // ---------------- random traffic vs model ----------------
    do_reset();
    mq.delete();
    m_in_frame = 0; m_wait = 0; m_exp = 8'h00; m_rx = 8'h00;
    m_edge = 0; m_deadline = 0;
    for (int f = 0; f < 250; f++) begin
      int gap  = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 25)
                                             : $urandom_range(1, 3);
      int kind = $urandom_range(0, 9);
      logic [7:0] t = 8'($urandom_range(0, 1));
      logic [7:0] e = 8'h40 + 8'($urandom_range(0, 3));
      repeat (gap) push(0, 0, 8'($urandom));
      fr.delete();
      if (kind <= 5) begin
        fr.push_back(t); fr.push_back(e); fr.push_back(8'h00);
      end else if (kind == 6) begin
        fr.push_back(t); fr.push_back(e);
        fr.push_back(8'($urandom_range(1, 255)));
      end else if (kind == 7) begin
        fr.push_back(t); fr.push_back(e); fr.push_back(8'h00);
        repeat ($urandom_range(1, 2)) fr.push_back(8'($urandom));
      end else if (kind == 8) begin
        int n = $urandom_range(0, 2);
        if (n > 0) fr.push_back(t);
        if (n > 1) fr.push_back(e);
      end else begin
        fr.push_back(8'($urandom_range(2, 255)));
        fr.push_back(e); fr.push_back(8'h00);
      end
      foreach (fr[i]) begin
        while ($urandom_range(0, 3) == 0) push(1, 0, 8'($urandom));
        push(1, 1, fr[i]);
      end
      if ($urandom_range(0, 3) == 0) push(1, 0, 8'($urandom));
    end
    repeat (20) push(0, 0, 8'h00);
    foreach (sq[i]) begin
      cyc(sq[i].fv, sq[i].dv, sq[i].data, sq[i].arm, sq[i].eid);
      model_edge(sq[i], x);
      check($sformatf("rand%0d", i), outs(), x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
